// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction-fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} fetch_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
//   clk_in/rst_in : clock, async active-low reset
//   inc_in        : count one event this cycle
//   clear_in      : return to zero
//   count_out     : current count, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             inc_in,
  input  logic             clear_in,
  output logic [WIDTH-1:0] count_out
);
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) count_out <= '0;
    else if (clear_in) count_out <= '0;
    else if (inc_in && !(&count_out)) count_out <= count_out + 1'b1;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer with single-outstanding imem requests and a one-entry output buffer
//   PC control : pc_current_in -> pc_src_out / pc_branch_out / pc_en_out
//   redirect   : branch_taken_in, branch_target_in
//   imem       : imem_req_out, imem_addr_out, imem_rvalid_in, imem_rdata_in
//   decode     : stall_in, instr_valid_out, instr_out, instr_pc_out
//   FETCH_CTRL_PERF_EN adds fetch/stall/flush saturating counters as outputs
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] pc_current_in,
  output logic             pc_src_out,
  output logic [WIDTH-1:0] pc_branch_out,
  output logic             pc_en_out,
  input  logic             branch_taken_in,
  input  logic [WIDTH-1:0] branch_target_in,
  output logic             imem_req_out,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic             imem_rvalid_in,
  input  logic [31:0]      imem_rdata_in,
  input  logic             stall_in,
  output logic             instr_valid_out,
  output logic [31:0]      instr_out,
  output logic [WIDTH-1:0] instr_pc_out
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [WIDTH-1:0] fetch_count_out,
  output logic [WIDTH-1:0] stall_count_out,
  output logic [WIDTH-1:0] flush_count_out
`endif
);
  fetch_state_e     state_q;
  logic             drop_q;
  logic             req_q;
  logic             valid_q;
  logic [31:0]      instr_q;
  logic [WIDTH-1:0] instr_pc_q;
  logic [WIDTH-1:0] req_pc_q;
  logic             consume;
  assign consume         = (state_q == HOLD) && !stall_in && !branch_taken_in;
  assign pc_en_out       = branch_taken_in || ((state_q == HOLD) && !stall_in);
  assign pc_src_out      = branch_taken_in;
  assign pc_branch_out   = branch_target_in;
  assign imem_req_out    = req_q;
  assign imem_addr_out   = pc_current_in;
  assign instr_valid_out = valid_q;
  assign instr_out       = instr_q;
  assign instr_pc_out    = instr_pc_q;
  // req_q is set on every transition into ISSUE so the request pulse is registered
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state_q    <= IDLE;
      drop_q     <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= '0;
      req_pc_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= ISSUE;
          req_q   <= 1'b1;
        end
        ISSUE: begin
          req_pc_q <= pc_current_in;
          req_q    <= 1'b0;
          state_q  <= WAIT;
          if (branch_taken_in) drop_q <= 1'b1;
        end
        WAIT: begin
          if (imem_rvalid_in) begin
            // a response for a squashed request (or one racing a redirect) is discarded
            if (drop_q || branch_taken_in) begin
              drop_q  <= 1'b0;
              req_q   <= 1'b1;
              state_q <= ISSUE;
            end else begin
              instr_q    <= imem_rdata_in;
              instr_pc_q <= req_pc_q;
              valid_q    <= 1'b1;
              state_q    <= HOLD;
            end
          end else if (branch_taken_in) drop_q <= 1'b1;
        end
        HOLD: begin
          if (branch_taken_in || !stall_in) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
`ifdef FETCH_CTRL_PERF_EN
  sat_counter #(.WIDTH(WIDTH)) u_fetch_cnt (
    .clk_in(clk_in), .rst_in(rst_in), .inc_in(consume), .clear_in(1'b0), .count_out(fetch_count_out)
  );
  sat_counter #(.WIDTH(WIDTH)) u_stall_cnt (
    .clk_in(clk_in), .rst_in(rst_in), .inc_in((state_q == HOLD) && stall_in), .clear_in(1'b0),
    .count_out(stall_count_out)
  );
  sat_counter #(.WIDTH(WIDTH)) u_flush_cnt (
    .clk_in(clk_in), .rst_in(rst_in), .inc_in(branch_taken_in), .clear_in(1'b0), .count_out(flush_count_out)
  );
`else
  logic unused_consume;
  assign unused_consume = consume;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl with a simple PC register model
module tb_fetch_ctrl;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] pc_current_in;
  logic        pc_src_out;
  logic [31:0] pc_branch_out;
  logic        pc_en_out;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        stall_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_count_out, stall_count_out, flush_count_out;
  logic [31:0] s0;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk_in = ~clk_in;
  fetch_ctrl #(.WIDTH(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pc_current_in(pc_current_in),
    .pc_src_out(pc_src_out), .pc_branch_out(pc_branch_out), .pc_en_out(pc_en_out),
    .branch_taken_in(branch_taken_in), .branch_target_in(branch_target_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_rvalid_in(imem_rvalid_in), .imem_rdata_in(imem_rdata_in),
    .stall_in(stall_in), .instr_valid_out(instr_valid_out), .instr_out(instr_out),
    .instr_pc_out(instr_pc_out)
`ifdef FETCH_CTRL_PERF_EN
    , .fetch_count_out(fetch_count_out), .stall_count_out(stall_count_out),
    .flush_count_out(flush_count_out)
`endif
  );
  // PC register of the IF datapath
  always @(posedge clk_in or negedge rst_in)
    if (!rst_in) pc_current_in <= '0;
    else if (pc_en_out) pc_current_in <= pc_src_out ? pc_branch_out : pc_current_in + 32'd4;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'd0, imem_req_out}, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid_out}, 32'd0);
    check({tag, "_instr"}, instr_out, 32'h0000_0013);
    check({tag, "_ipc"}, instr_pc_out, 32'd0);
`ifdef FETCH_CTRL_PERF_EN
    check({tag, "_fcnt"}, fetch_count_out, 32'd0);
    check({tag, "_scnt"}, stall_count_out, 32'd0);
    check({tag, "_xcnt"}, flush_count_out, 32'd0);
`endif
  endtask
  initial begin
    rst_in = 1'b0; branch_taken_in = 1'b0; branch_target_in = '0;
    imem_rvalid_in = 1'b0; imem_rdata_in = '0; stall_in = 1'b0;
    #12;
    check_reset_outputs("rst");
    check("rst_pcen", {31'd0, pc_en_out}, 32'd0);
    rst_in = 1'b1;
    tick;
    check("t1_req", {31'd0, imem_req_out}, 32'd1);
    check("t1_addr", imem_addr_out, 32'h0);
    tick;
    check("t1_wait_req", {31'd0, imem_req_out}, 32'd0);
    imem_rvalid_in = 1'b1; imem_rdata_in = 32'hAAAA_0001;
    tick;
    imem_rvalid_in = 1'b0;
    check("t1_valid", {31'd0, instr_valid_out}, 32'd1);
    check("t1_instr", instr_out, 32'hAAAA_0001);
    check("t1_ipc", instr_pc_out, 32'h0);
    stall_in = 1'b1;
    #1;
`ifdef FETCH_CTRL_PERF_EN
    s0 = stall_count_out;
`endif
    check("t2_pcen0", {31'd0, pc_en_out}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("t2_valid", {31'd0, instr_valid_out}, 32'd1);
      check("t2_instr", instr_out, 32'hAAAA_0001);
      check("t2_ipc", instr_pc_out, 32'h0);
      check("t2_pcen", {31'd0, pc_en_out}, 32'd0);
    end
    tick;
    stall_in = 1'b0;
    #1;
`ifdef FETCH_CTRL_PERF_EN
    check("t2_stall_delta", stall_count_out - s0, 32'd4);
`endif
    check("t2_cons_pcen", {31'd0, pc_en_out}, 32'd1);
    check("t2_cons_src", {31'd0, pc_src_out}, 32'd0);
    tick;
    check("t2_next_valid", {31'd0, instr_valid_out}, 32'd0);
    check("t2_next_req", {31'd0, imem_req_out}, 32'd1);
    check("t2_next_addr", imem_addr_out, 32'h4);
`ifdef FETCH_CTRL_PERF_EN
    check("t2_fetch_cnt", fetch_count_out, 32'd1);
`endif
    tick;
    branch_taken_in = 1'b1; branch_target_in = 32'h100;
    #1;
    check("t3_pcen", {31'd0, pc_en_out}, 32'd1);
    check("t3_src", {31'd0, pc_src_out}, 32'd1);
    check("t3_tgt", pc_branch_out, 32'h100);
    tick;
    branch_taken_in = 1'b0;
    check("t3_wait_req", {31'd0, imem_req_out}, 32'd0);
    tick;
    imem_rvalid_in = 1'b1; imem_rdata_in = 32'hDEAD_BEEF;
    tick;
    imem_rvalid_in = 1'b0;
    check("t3_no_valid", {31'd0, instr_valid_out}, 32'd0);
    check("t3_req", {31'd0, imem_req_out}, 32'd1);
    check("t3_addr", imem_addr_out, 32'h100);
    tick;
    imem_rvalid_in = 1'b1; imem_rdata_in = 32'h1234_5678;
    branch_taken_in = 1'b1; branch_target_in = 32'h200;
    #1;
    check("t4_pcen", {31'd0, pc_en_out}, 32'd1);
    check("t4_src", {31'd0, pc_src_out}, 32'd1);
    tick;
    imem_rvalid_in = 1'b0; branch_taken_in = 1'b0;
    check("t4_no_valid", {31'd0, instr_valid_out}, 32'd0);
    check("t4_req", {31'd0, imem_req_out}, 32'd1);
    check("t4_addr", imem_addr_out, 32'h200);
    tick;
    imem_rvalid_in = 1'b1; imem_rdata_in = 32'hBBBB_0002;
    tick;
    imem_rvalid_in = 1'b0;
    check("t5_valid", {31'd0, instr_valid_out}, 32'd1);
    check("t5_instr", instr_out, 32'hBBBB_0002);
    check("t5_ipc", instr_pc_out, 32'h200);
    stall_in = 1'b1; branch_taken_in = 1'b1; branch_target_in = 32'h300;
    #1;
    check("t5_pcen", {31'd0, pc_en_out}, 32'd1);
    check("t5_src", {31'd0, pc_src_out}, 32'd1);
    tick;
    stall_in = 1'b0; branch_taken_in = 1'b0;
    check("t5_drop_valid", {31'd0, instr_valid_out}, 32'd0);
    check("t5_req", {31'd0, imem_req_out}, 32'd1);
    check("t5_addr", imem_addr_out, 32'h300);
`ifdef FETCH_CTRL_PERF_EN
    check("t5_flush_cnt", flush_count_out, 32'd3);
    check("t5_fetch_cnt", fetch_count_out, 32'd1);
`endif
    tick;
    #2;
    rst_in = 1'b0;
    #1;
    check_reset_outputs("t6");
    tick;
    rst_in = 1'b1;
    tick;
    check("t6_req", {31'd0, imem_req_out}, 32'd1);
    check("t6_addr", imem_addr_out, 32'h0);
    tick;
    imem_rvalid_in = 1'b1; imem_rdata_in = 32'hCCCC_0003;
    tick;
    imem_rvalid_in = 1'b0;
    check("t6_valid", {31'd0, instr_valid_out}, 32'd1);
    check("t6_instr", instr_out, 32'hCCCC_0003);
    check("t6_ipc", instr_pc_out, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch stage. Drives the PC-select, branch-target and PC-enable inputs of the IF datapath, issues single-outstanding requests to instruction memory at the current PC, and holds each returned instruction in a one-entry output buffer until decode accepts it. Branch redirects are handled by squashing the in-flight or buffered instruction. Sits between the IF datapath, the instruction memory port and the decode stage.

## Interface
- WIDTH, 32, PC/address width
- clk_in  input  1  clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- pc_current_in  input  WIDTH  current PC from the IF datapath
- pc_src_out  output  1  1 selects pc_branch_out as next PC, 0 selects PC+4
- pc_branch_out  output  WIDTH  redirect target, combinational copy of branch_target_in
- pc_en_out  output  1  PC register load enable for this cycle
- branch_taken_in  input  1  redirect request from execute, single-cycle
- branch_target_in  input  WIDTH  redirect target, valid with branch_taken_in
- imem_req_out  output  1  single-cycle request pulse
- imem_addr_out  output  WIDTH  request address, equals pc_current_in while imem_req_out=1
- imem_rvalid_in  input  1  response valid, at least 1 cycle after request
- imem_rdata_in  input  32  response instruction
- stall_in  input  1  decode not ready
- instr_valid_out  output  1  output buffer holds a live instruction
- instr_out  output  32  buffered instruction
- instr_pc_out  output  WIDTH  PC of buffered instruction

## Operation
- States: IDLE, ISSUE, WAIT, HOLD. Reset state: IDLE.
- IDLE: no request. Next state is ISSUE.
- ISSUE: imem_req_out=1, imem_addr_out=pc_current_in, the address is latched internally as req_pc. Next state is WAIT.
- WAIT without rvalid: stay in WAIT.
- WAIT with rvalid and drop=0: instr_out←rdata, instr_pc_out←req_pc, valid←1, next state HOLD.
- WAIT with rvalid and drop=1: discard the response, clear drop, next state ISSUE.
- HOLD: instr_valid_out=1.
  - If !stall_in, the instruction is consumed: valid←0, pc_en_out=1, pc_src_out=0, next state ISSUE.
  - While stall_in=1, stay in HOLD with all outputs stable.
- Redirect (branch_taken_in=1) in any state: pc_en_out=1, pc_src_out=1 that cycle.
  - In ISSUE, or in WAIT without rvalid: set drop. In ISSUE the request still issues at the old PC.
  - In WAIT with rvalid the same cycle: discard the response, next state ISSUE.
  - In HOLD: valid←0, next state ISSUE. Redirect has priority over consume, regardless of stall_in.
  - In IDLE: next state ISSUE.
- A redirect while drop is already set keeps drop=1, and only one response is dropped.
- imem_rvalid_in outside WAIT is ignored. The memory shares rst_in, so no stale responses follow reset.
- Outside the cases above, pc_en_out=0 and pc_src_out=0.

## Timing
- Reset values: state IDLE, drop=0, imem_req_out=0, instr_valid_out=0, instr_out=32'h0000_0013 (NOP), instr_pc_out=0, req_pc=0, and perf counters 0.
- Reset mid-operation clears everything asynchronously, and any outstanding request is abandoned.
- Latency: rvalid in cycle t gives instr_valid_out=1 in cycle t+1.
- Peak throughput is one instruction per 3 cycles (ISSUE, WAIT with immediate rvalid, HOLD consumed).
- pc_en_out, pc_src_out and pc_branch_out are combinational from state and inputs. The PC updates at the next edge.
- imem_req_out, instr_* and instr_valid_out are driven from registered state only.

## Configuration
- FETCH_CTRL_PERF_EN defined adds three outputs, each WIDTH wide:
  - fetch_count_out: +1 per accepted instruction
  - stall_count_out: +1 per HOLD cycle with stall_in=1
  - flush_count_out: +1 per branch_taken_in cycle
- All three counters saturate at all-ones and reset to 0.
- FETCH_CTRL_PERF_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- fetch_pkg holds the fetch_state_e enum (IDLE, ISSUE, WAIT, HOLD) and the NOP_INSTR constant 32'h0000_0013.
- Sub-module sat_counter (parameter WIDTH, with inc and clear inputs) is instantiated three times when FETCH_CTRL_PERF_EN is defined.

## Test plan
- Reset release with pc_current_in=0 and rvalid 1 cycle after the request → req at cycle 1, instr_valid_out at cycle 3 with instr_pc_out=0, instr_out=rdata.
- stall_in=1 for 4 cycles in HOLD → instr_out and instr_pc_out stable and no pc_en_out; the stall_count_out delta is 4 (perf build).
- branch_taken_in in WAIT with target 0x100, rvalid 2 cycles later → response discarded, next request addr=0x100, no instr_valid_out for the old PC.
- branch_taken_in and imem_rvalid_in in the same WAIT cycle → no buffer load, pc_src_out=1, next ISSUE.
- branch_taken_in in HOLD with stall_in=1 → instr_valid_out drops next cycle, pc_en_out=1 and pc_src_out=1 that cycle.
- rst_in asserted in WAIT → all outputs at reset values immediately; after release, the sequence restarts from IDLE.
